// File: rtl/timer_irq_if.sv
// Data-memory bus bundle between the CPU (master) and the timer peripheral (slave).
interface timer_irq_if;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemRd, MemWr, Addr, WriteData, input ReadData);
    modport slave  (input MemRd, MemWr, Addr, WriteData, output ReadData);
endinterface

// File: rtl/timer_irq.sv
// Memory-mapped interval timer: TH reload, TL counter, TCON control, level IRQ on overflow.
// Define TIMER_SYSTICK_EN to add a read-only free-running SYSTICK counter at offset 0x0C.
module timer_irq #(
    parameter logic [31:0] ADDR_BASE = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic         clk,
    input  logic         reset,
    timer_irq_if.slave   bus,
    output logic         IRQ
);

    localparam logic [7:0] PCNT_LAST = 8'(PRESCALE - 1);

    logic [31:0] th;
    logic [31:0] tl;
    logic        en;
    logic        ie;
    logic        irq_flag;
    logic [7:0]  pcnt;

    logic hit_th, hit_tl, hit_tcon;
    logic tick, overflow;

    assign hit_th   = (bus.Addr == ADDR_BASE);
    assign hit_tl   = (bus.Addr == ADDR_BASE + 32'h4);
    assign hit_tcon = (bus.Addr == ADDR_BASE + 32'h8);

    assign tick     = en && (pcnt == PCNT_LAST);
    assign overflow = (tl == 32'hFFFF_FFFF);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (!en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
        end else if (bus.MemWr && hit_th) begin
            th <= bus.WriteData;
        end
    end

    // A bus write to TL beats the tick; reload reads TH before any same-edge TH write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tl <= '0;
        end else if (bus.MemWr && hit_tl) begin
            tl <= bus.WriteData;
        end else if (tick) begin
            tl <= overflow ? th : tl + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            irq_flag <= 1'b0;
        end else begin
            if (bus.MemWr && hit_tcon) begin
                en <= bus.WriteData[0];
                ie <= bus.WriteData[1];
            end
            // Hardware set has priority over the software write-1-to-clear.
            if (tick && overflow && ie) begin
                irq_flag <= 1'b1;
            end else if (bus.MemWr && hit_tcon && bus.WriteData[2]) begin
                irq_flag <= 1'b0;
            end
        end
    end

`ifdef TIMER_SYSTICK_EN
    logic [31:0] systick;
    logic        hit_systick;

    assign hit_systick = (bus.Addr == ADDR_BASE + 32'hC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`endif

    // NOTE: ReadData gets a default before any branch so no latch is inferred.
    always_comb begin
        bus.ReadData = '0;
        if (bus.MemRd) begin
            if (hit_th) begin
                bus.ReadData = th;
            end else if (hit_tl) begin
                bus.ReadData = tl;
            end else if (hit_tcon) begin
                bus.ReadData = {29'd0, irq_flag, ie, en};
            end
`ifdef TIMER_SYSTICK_EN
            else if (hit_systick) begin
                bus.ReadData = systick;
            end
`endif
        end
    end

    assign IRQ = ie & irq_flag;

endmodule

// File: doc/timer_irq.md
# timer_irq

Memory-mapped interval timer peripheral for the single-cycle MIPS CPU. Sits on the data-memory bus next to data RAM and drives the `IRQ` input of the main `Control` decoder, so that `Control` selects the interrupt PCSrc path. Software loads a reload value and a start count, enables the timer, and takes an interrupt on every counter overflow until it acknowledges.

## Interface
- `ADDR_BASE`, 32'h4000_0000, base address of the register window.
- `PRESCALE`, 1, number of enabled clock cycles per TL increment; legal range 1..256.
- `reset`  in  1  asynchronous, active-low reset.
- `clk`  in  1  CPU clock; all state updates on the rising edge.
- `MemRd`  in  1  bus read strobe from `Control`.
- `MemWr`  in  1  bus write strobe from `Control`.
- `Addr`  in  32  byte address from the ALU result.
- `WriteData`  in  32  store data (rt value).
- `ReadData`  out  32  read data, combinational.
- `IRQ`  out  1  interrupt request to `Control`, registered-derived, level.

## Operation
- Register map, word offsets from `ADDR_BASE`:
  - 0x00 TH: reload value.
  - 0x04 TL: counter.
  - 0x08 TCON: bit0 = EN, bit1 = IE, bit2 = IF. Bits 31:3 read 0.
- Hit only on exact word match `Addr == ADDR_BASE + off`. Any other address: writes ignored, `ReadData` = 0.
- `ReadData` = selected register when `MemRd` and hit; otherwise 0. Reads have no side effects.
- Write TH/TL: full 32-bit load.
- Write TCON: bits 1:0 take `WriteData[1:0]`. Bit2 is write-1-to-clear: `WriteData[2]`=1 clears IF, 0 leaves it unchanged.
- Prescaler `pcnt`, 8-bit:
  - Counts while EN=1.
  - Held at 0 while EN=0.
  - A tick is issued when `pcnt == PRESCALE-1`; `pcnt` then returns to 0.
- On a tick:
  - If `TL == 32'hFFFF_FFFF` (overflow): TL <= TH, and if IE=1, IF <= 1.
  - Otherwise: TL <= TL + 1, with 32-bit wrap arithmetic.
- `IRQ = IE & IF`. It stays asserted until software clears IF or clears IE.
- Simultaneous events in one cycle:
  - TL write and tick: the written value wins; no increment that cycle.
  - TH write and overflow: reload uses the old TH; TH takes the new value.
  - IF clear (W1C) and overflow setting IF: set wins, so IF stays 1.
  - TCON write clearing EN and a tick: the tick still takes effect; counting stops from the next cycle.
- Reset (asserted at any time, including mid-count): TH = 0, TL = 0, TCON = 0, `pcnt` = 0, `IRQ` = 0. `ReadData` follows its combinational rule.

## Timing
- Writes land at the rising edge ending the store instruction's cycle. A load in the next cycle sees the new value.
- `ReadData` valid in the same cycle as `MemRd`/`Addr`; zero cycles of latency.
- Overflow tick at edge N: `IRQ` high after edge N, and visible to `Control` in cycle N+1.
- With PRESCALE = P and EN set at edge 0, TL increments at edges P, 2P, 3P, and so on.
- Period from reload to IRQ: (2^32 − TH) × PRESCALE cycles.
- No handshake; the bus is single-cycle, and a store is one write strobe per cycle.

## Configuration
- `TIMER_SYSTICK_EN` defined:
  - Adds a read-only free-running 32-bit SYSTICK at offset 0x0C.
  - SYSTICK increments every clock regardless of EN and wraps at 2^32.
  - Reset value is 0. Writes to 0x0C are ignored.
- Not defined: offset 0x0C behaves as unmapped (reads 0, writes ignored), and no SYSTICK register is built.

## Test plan
- Reset mid-count: TL = 5 running, pulse `reset` low asynchronously between edges -> TH/TL/TCON read 0 and `IRQ` = 0 immediately, without waiting for a clock edge.
- Basic overflow: PRESCALE = 1, write TH = 32'hFFFF_FFF0, TL = 32'hFFFF_FFFE, TCON = 3 -> TL reads FFFF_FFFF after 1 cycle; after the 2nd edge TL = FFFF_FFF0, TCON = 7, `IRQ` = 1; next IRQ 16 cycles later.
- Acknowledge race: with IF = 1, write TCON = 7 on the same edge as the next overflow -> IF stays 1 and `IRQ` stays 1. Write TCON = 7 on a non-overflow edge -> IF clears, TCON reads 3, `IRQ` drops to 0.
- Prescaler: PRESCALE = 4, TL = 0, TCON = 1 -> TL = 1 after 4 edges and 2 after 8. Write TCON = 0, then 1 again -> the next increment comes 4 edges after re-enable.
- Bus decode: write 32'h1234 to `ADDR_BASE + 0x10` and to `ADDR_BASE + 0x05` -> no register changes. Read TL with `MemRd` = 0 -> `ReadData` = 0. Write TL with `MemWr` = 0 -> TL unchanged.
- `TIMER_SYSTICK_EN` build: SYSTICK reads N+3 three cycles after reading N, and writing 0x0C has no effect. Non-`TIMER_SYSTICK_EN` build: 0x0C reads 0.
